sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter_if.sv | 38 +++
 rtl/sp_ram_arbiter.sv | 97 +++++++++
 tb/tb_sp_ram_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter_if
// Purpose : one request port of the single-port RAM arbiter.
// Signals : req    - request, held until gnt
//           addr   - byte address
//           we     - write (1) / read (0)
//           be     - byte enables
//           wdata  - write data
//           gnt    - request accepted this cycle (combinational)
//           rvalid - response valid, one cycle after gnt
//           rdata  - read data while rvalid, 0 otherwise / for writes
// Modports: master (requester side), slave (arbiter side)
// ---------------------------------------------------------------------------
interface sp_ram_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter
// Purpose : two-port round-robin arbiter in front of a single-port RAM with
//           one cycle read latency. Grants are combinational, responses come
//           exactly one cycle after the grant, no request buffering.
// Ports   : clk, rst_i (sync, active-high)
//           a_port, b_port          - request ports (sp_ram_arbiter_if.slave)
//           ram_en_o/addr/we/be/wdata - RAM command, muxed from granted port
//           ram_rdata_i             - RAM read data, valid cycle after a read
// ---------------------------------------------------------------------------
module sp_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_i,
   sp_ram_arbiter_if.slave         a_port,
   sp_ram_arbiter_if.slave         b_port,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("sp_ram_arbiter: DATA_WIDTH must be a multiple of 8");
   end

   logic r_last_gnt_b;   // 1: last grant went to b, so a wins next contention
   logic r_rsp_valid;
   logic r_rsp_port_b;
   logic r_rsp_we;

   logic w_a_gnt;
   logic w_b_gnt;
   logic w_any_gnt;
   logic w_a_rvalid;
   logic w_b_rvalid;

   // Round-robin grant; reset masks everything in the same cycle
   assign w_a_gnt   = !rst_i && a_port.req && (!b_port.req ||  r_last_gnt_b);
   assign w_b_gnt   = !rst_i && b_port.req && (!a_port.req || !r_last_gnt_b);
   assign w_any_gnt = w_a_gnt || w_b_gnt;

   assign a_port.gnt = w_a_gnt;
   assign b_port.gnt = w_b_gnt;

   // RAM command mux; address/wdata default to port a when idle
   assign ram_en_o    = w_any_gnt;
   assign ram_addr_o  = w_b_gnt ? b_port.addr  : a_port.addr;
   assign ram_wdata_o = w_b_gnt ? b_port.wdata : a_port.wdata;
   assign ram_we_o    = (w_a_gnt && a_port.we) || (w_b_gnt && b_port.we);

   always_comb begin
      ram_be_o = '0;
      if (w_a_gnt) begin
         ram_be_o = a_port.be;
      end else if (w_b_gnt) begin
         ram_be_o = b_port.be;
      end
   end

   // Response state: one entry, since a response never outlives one cycle
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_last_gnt_b <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_port_b <= 1'b0;
         r_rsp_we     <= 1'b0;
      end else begin
         r_rsp_valid <= w_any_gnt;
         if (w_any_gnt) begin
            r_last_gnt_b <= w_b_gnt;
            r_rsp_port_b <= w_b_gnt;
            r_rsp_we     <= ram_we_o;
         end
      end
   end

   // rst_i gates the response combinationally so a grant just before reset
   // produces no rvalid in the reset cycle
   assign w_a_rvalid = !rst_i && r_rsp_valid && !r_rsp_port_b;
   assign w_b_rvalid = !rst_i && r_rsp_valid &&  r_rsp_port_b;

   assign a_port.rvalid = w_a_rvalid;
   assign b_port.rvalid = w_b_rvalid;

   // Write responses carry zero data
   assign a_port.rdata = (w_a_rvalid && !r_rsp_we) ? ram_rdata_i : DATA_WIDTH'(0);
   assign b_port.rdata = (w_b_rvalid && !r_rsp_we) ? ram_rdata_i : DATA_WIDTH'(0);

   logic w_unused;
   assign w_unused = ^{BE_WIDTH'(0)};
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_arbiter
// Purpose : table-driven bench for sp_ram_arbiter with a behavioural RAM,
//           a reference memory model and a response scoreboard queue.
// ---------------------------------------------------------------------------
module tb_sp_ram_arbiter;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic           clk = 1'b0;
   logic           rst_i;
   logic           ram_en_o;
   logic [AW-1:0]  ram_addr_o;
   logic           ram_we_o;
   logic [BW-1:0]  ram_be_o;
   logic [DW-1:0]  ram_wdata_o;
   logic [DW-1:0]  ram_rdata_i;

   always #5 clk = ~clk;

   sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
   sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_i       (rst_i),
      .a_port      (a_if),
      .b_port      (b_if),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i)
   );

   // Behavioural single-port RAM, one cycle read latency, byte enables
   logic [DW-1:0] ram_mem [0:(1<<(AW-2))-1];
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int i = 0; i < int'(BW); i++)
               if (ram_be_o[i]) ram_mem[ram_addr_o[AW-1:2]][i*8 +: 8] <= ram_wdata_o[i*8 +: 8];
         end else begin
            ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
         end
      end
   end

   typedef struct {
      logic          rst;
      logic          a_req;
      logic          a_we;
      logic [AW-1:0] a_addr;
      logic [BW-1:0] a_be;
      logic [DW-1:0] a_wdata;
      logic          b_req;
      logic          b_we;
      logic [AW-1:0] b_addr;
      logic [BW-1:0] b_be;
      logic [DW-1:0] b_wdata;
      logic          exp_a_gnt;
      logic          exp_b_gnt;
   } vec_t;

   typedef struct {
      logic          port_b;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;

   vec_t          vecs[$];
   rsp_t          sb[$];
   logic [DW-1:0] mdl_mem [int];
   int            cyc   = 0;
   int            total = 0;
   int            bad   = 0;

   function automatic vec_t mk(input logic rst,
                               input logic a_req, input logic a_we, input logic [AW-1:0] a_addr,
                               input logic [BW-1:0] a_be, input logic [DW-1:0] a_wdata,
                               input logic b_req, input logic b_we, input logic [AW-1:0] b_addr,
                               input logic [BW-1:0] b_be, input logic [DW-1:0] b_wdata,
                               input logic ea, input logic eb);
      vec_t v;
      v.rst = rst;
      v.a_req = a_req; v.a_we = a_we; v.a_addr = a_addr; v.a_be = a_be; v.a_wdata = a_wdata;
      v.b_req = b_req; v.b_we = b_we; v.b_addr = b_addr; v.b_be = b_be; v.b_wdata = b_wdata;
      v.exp_a_gnt = ea; v.exp_b_gnt = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle, check the combinational and response outputs,
   // then advance the reference model and scoreboard
   task automatic apply_vec(input vec_t v);
      rsp_t          r;
      logic          exp_av, exp_bv, any;
      logic [DW-1:0] exp_ad, exp_bd, cur;
      logic          g_we;
      logic [AW-1:0] g_addr;
      logic [BW-1:0] g_be;
      logic [DW-1:0] g_wdata;
      int            key;

      rst_i      = v.rst;
      a_if.req   = v.a_req; a_if.we = v.a_we; a_if.addr = v.a_addr;
      a_if.be    = v.a_be;  a_if.wdata = v.a_wdata;
      b_if.req   = v.b_req; b_if.we = v.b_we; b_if.addr = v.b_addr;
      b_if.be    = v.b_be;  b_if.wdata = v.b_wdata;
      @(negedge clk);

      any = v.exp_a_gnt || v.exp_b_gnt;
      chk("a_gnt",  DW'(a_if.gnt), DW'(v.exp_a_gnt));
      chk("b_gnt",  DW'(b_if.gnt), DW'(v.exp_b_gnt));
      chk("ram_en", DW'(ram_en_o), DW'(any));

      g_we = 1'b0; g_addr = v.a_addr; g_be = '0; g_wdata = v.a_wdata;
      if (v.exp_a_gnt) begin
         g_we = v.a_we; g_be = v.a_be;
      end else if (v.exp_b_gnt) begin
         g_we = v.b_we; g_addr = v.b_addr; g_be = v.b_be; g_wdata = v.b_wdata;
      end
      chk("ram_we",    DW'(ram_we_o),   DW'(g_we));
      chk("ram_be",    DW'(ram_be_o),   DW'(g_be));
      chk("ram_addr",  DW'(ram_addr_o), DW'(g_addr));
      chk("ram_wdata", ram_wdata_o,     g_wdata);

      exp_av = 1'b0; exp_bv = 1'b0; exp_ad = '0; exp_bd = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         if (!v.rst) begin
            if (r.port_b) begin exp_bv = 1'b1; exp_bd = r.data; end
            else          begin exp_av = 1'b1; exp_ad = r.data; end
         end
      end
      chk("a_rvalid", DW'(a_if.rvalid), DW'(exp_av));
      chk("b_rvalid", DW'(b_if.rvalid), DW'(exp_bv));
      chk("a_rdata",  a_if.rdata, exp_ad);
      chk("b_rdata",  b_if.rdata, exp_bd);

      if (any) begin
         key = int'(g_addr >> 2);
         cur = mdl_mem.exists(key) ? mdl_mem[key] : '0;
         r.port_b = v.exp_b_gnt;
         r.due    = cyc + 1;
         if (g_we) begin
            for (int i = 0; i < int'(BW); i++)
               if (g_be[i]) cur[i*8 +: 8] = g_wdata[i*8 +: 8];
            mdl_mem[key] = cur;
            r.data = '0;
         end else begin
            r.data = cur;
         end
         sb.push_back(r);
      end

      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.be = '0; a_if.wdata = '0;
      b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.be = '0; b_if.wdata = '0;

      // rst a: req we addr be wdata | b: req we addr be wdata | exp a_gnt b_gnt
      vecs.push_back(mk(1, 1,1,'h10,'hF,'h0,           1,0,'h10,'hF,'h0,        0,0)); // reset masks requests
      vecs.push_back(mk(1, 0,0,'h0, 'h0,'h0,           0,0,'h0, 'h0,'h0,        0,0));
      vecs.push_back(mk(0, 1,1,'h10,'hF,'hDEADBEEF,    0,0,'h0, 'h0,'h0,        1,0)); // lone write a
      vecs.push_back(mk(0, 0,0,'h0, 'h0,'h0,           1,0,'h10,'hF,'h0,        0,1)); // lone read b
      vecs.push_back(mk(0, 0,0,'h0, 'h0,'h0,           0,0,'h0, 'h0,'h0,        0,0));
      vecs.push_back(mk(0, 1,1,'h10,'h2,'h0000AB00,    0,0,'h0, 'h0,'h0,        1,0)); // partial write
      vecs.push_back(mk(0, 0,0,'h0, 'h0,'h0,           1,0,'h10,'hF,'h0,        0,1));
      vecs.push_back(mk(0, 0,0,'h0, 'h0,'h0,           0,0,'h0, 'h0,'h0,        0,0));
      vecs.push_back(mk(1, 0,0,'h0, 'h0,'h0,           0,0,'h0, 'h0,'h0,        0,0));
      // full contention, a writes / b reads the same word, fields change each cycle
      vecs.push_back(mk(0, 1,1,'h20,'hF,'h11111111,    1,0,'h20,'hF,'h0,        1,0));
      vecs.push_back(mk(0, 1,1,'h20,'hF,'h22222222,    1,0,'h20,'hF,'h0,        0,1));
      vecs.push_back(mk(0, 1,1,'h20,'hF,'h33333333,    1,0,'h20,'hF,'h0,        1,0));
      vecs.push_back(mk(0, 1,1,'h20,'hF,'h44444444,    1,0,'h20,'hF,'h0,        0,1));
      vecs.push_back(mk(0, 1,1,'h24,'hC,'h55667788,    1,0,'h20,'hF,'h0,        1,0));
      vecs.push_back(mk(0, 1,1,'h24,'hF,'h99999999,    1,0,'h24,'hF,'h0,        0,1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0,0,'h4,'h0,'h0,         0,0,'h0, 'h0,'h0,        0,0));
      vecs.push_back(mk(0, 1,0,'h20,'hF,'h0,           1,0,'h24,'hF,'h0,        1,0)); // last=b held
      vecs.push_back(mk(0, 1,0,'h24,'hF,'h0,           0,0,'h0, 'h0,'h0,        1,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0,0,'h0,'h0,'h0,         0,0,'h0, 'h0,'h0,        0,0));
      vecs.push_back(mk(0, 1,1,'h20,'hF,'hABCDEF01,    1,0,'h20,'hF,'h0,        0,1)); // last=a held

      @(posedge clk);
      #1;
      foreach (vecs[i]) apply_vec(vecs[i]);

      // Reset in the cycle after a grant kills that response, then a lone
      // b request is served right out of reset
      apply_vec(mk(0, 1,0,'h10,'hF,'h0,  0,0,'h0, 'h0,'h0,  1,0));
      apply_vec(mk(1, 1,0,'h10,'hF,'h0,  0,0,'h0, 'h0,'h0,  0,0));
      apply_vec(mk(0, 0,0,'h0, 'h0,'h0,  1,0,'h10,'hF,'h0,  0,1));
      apply_vec(mk(0, 0,0,'h0, 'h0,'h0,  0,0,'h0, 'h0,'h0,  0,0));

      // The partial write must have merged into the original word
      chk("merged_word", mdl_mem[4], 32'hDEADABEF);
      chk("sb_drained",  DW'(sb.size()), DW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
